// File: rtl/frame_check_pkg.sv
// Shared definitions for the frame checker: FSM state encoding and a width helper.
package frame_check_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } fc_state_e;

   // Bits needed to hold 0..n-1, never less than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ref_pattern_gen.sv
// Reference word source for the frame checker: incrementing pattern starting at SEED.
module ref_pattern_gen #(
   parameter int                DATA_W = 32,
   parameter logic [DATA_W-1:0] SEED   = '0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load,
   input  logic              i_advance,
   output logic [DATA_W-1:0] o_ref
);

   logic [DATA_W-1:0] ref_q, ref_d;

   always_comb begin
      ref_d = ref_q;
      if (i_load)
         ref_d = SEED;
      else if (i_advance)
         ref_d = ref_q + DATA_W'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         ref_q <= SEED;
      else
         ref_q <= ref_d;
   end

   assign o_ref = ref_q;

endmodule

// File: rtl/frame_checker.sv
// Per-frame read-back checker: compares valid beats against a reference pattern
// and reports pass/fail, saturating error count, first-mismatch index and timeout.
//
// state | meaning
// IDLE  | no frame in progress, error status from last frame held
// ARMED | started, waiting for the first beat
// CHECK | comparing beats until the last one of the frame
// DONE  | one-cycle verdict (done / valid / timeout pulses)
module frame_checker
   import frame_check_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                FRAME_LEN   = 64,
   parameter int                ERR_CNT_W   = 8,
   parameter int                TIMEOUT_CYC = 256,
   parameter logic [DATA_W-1:0] SEED        = '0,
   localparam int               IDX_W       = clog2_min1(FRAME_LEN)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic                 i_data_valid,
   input  logic [DATA_W-1:0]    i_data,
   output logic                 o_busy,
   output logic                 o_checking_done,
   output logic                 o_valid_frame,
   output logic                 o_timeout,
   output logic [ERR_CNT_W-1:0] o_err_cnt,
   output logic                 o_first_err_vld,
   output logic [IDX_W-1:0]     o_first_err_idx
);

   localparam int               TMO_W    = clog2_min1(TIMEOUT_CYC);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

   fc_state_e            state_q, state_d;
   logic [IDX_W-1:0]     beat_idx_q, beat_idx_d;
   logic [TMO_W-1:0]     idle_cnt_q, idle_cnt_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic                 first_err_vld_q, first_err_vld_d;
   logic [IDX_W-1:0]     first_err_idx_q, first_err_idx_d;
   logic                 timeout_q, timeout_d;

   logic                 ref_load;
   logic                 ref_adv;
   logic [DATA_W-1:0]    ref_word;
   logic                 err_sat;

   ref_pattern_gen #(
      .DATA_W (DATA_W),
      .SEED   (SEED)
   ) u_ref_gen (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_load    (ref_load),
      .i_advance (ref_adv),
      .o_ref     (ref_word)
   );

   assign err_sat = &err_cnt_q;

   always_comb begin
      state_d         = state_q;
      beat_idx_d      = beat_idx_q;
      idle_cnt_d      = idle_cnt_q;
      err_cnt_d       = err_cnt_q;
      first_err_vld_d = first_err_vld_q;
      first_err_idx_d = first_err_idx_q;
      timeout_d       = timeout_q;
      ref_load        = 1'b0;
      ref_adv         = 1'b0;

      // Start overrides everything, including a beat arriving in the same cycle.
      if (i_start) begin
         state_d         = ST_ARMED;
         beat_idx_d      = '0;
         idle_cnt_d      = TMO_LOAD;
         err_cnt_d       = '0;
         first_err_vld_d = 1'b0;
         first_err_idx_d = '0;
         timeout_d       = 1'b0;
         ref_load        = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (state_q == ST_DONE)
                  state_d = ST_IDLE;
               // Beats outside a frame are overrun: counted, never compared.
               if (i_data_valid && !err_sat)
                  err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            ST_ARMED, ST_CHECK: begin
               if (i_data_valid) begin
                  idle_cnt_d = TMO_LOAD;
                  ref_adv    = 1'b1;
                  beat_idx_d = beat_idx_q + IDX_W'(1);
                  if (i_data != ref_word) begin
                     if (!err_sat)
                        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                     if (!first_err_vld_q) begin
                        first_err_vld_d = 1'b1;
                        first_err_idx_d = beat_idx_q;
                     end
                  end
                  state_d = (beat_idx_q == LAST_IDX) ? ST_DONE : ST_CHECK;
               end else if (idle_cnt_q == '0) begin
                  state_d   = ST_DONE;
                  timeout_d = 1'b1;
               end else begin
                  idle_cnt_d = idle_cnt_q - TMO_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q         <= ST_IDLE;
         beat_idx_q      <= '0;
         idle_cnt_q      <= '0;
         err_cnt_q       <= '0;
         first_err_vld_q <= 1'b0;
         first_err_idx_q <= '0;
         timeout_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         beat_idx_q      <= beat_idx_d;
         idle_cnt_q      <= idle_cnt_d;
         err_cnt_q       <= err_cnt_d;
         first_err_vld_q <= first_err_vld_d;
         first_err_idx_q <= first_err_idx_d;
         timeout_q       <= timeout_d;
      end
   end

   assign o_busy          = (state_q == ST_ARMED) || (state_q == ST_CHECK);
   assign o_checking_done = (state_q == ST_DONE);
   assign o_valid_frame   = (state_q == ST_DONE) && (err_cnt_q == '0) && !timeout_q;
   assign o_timeout       = (state_q == ST_DONE) && timeout_q;
   assign o_err_cnt       = err_cnt_q;
   assign o_first_err_vld = first_err_vld_q;
   assign o_first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_frame_checker.sv
// Directed bench for frame_checker: 8-beat frames, SEED 0x10, 2-bit error counter, 16-cycle timeout.
module tb_frame_checker;

   localparam int DATA_W      = 16;
   localparam int FRAME_LEN   = 8;
   localparam int ERR_CNT_W   = 2;
   localparam int TIMEOUT_CYC = 16;
   localparam int IDX_W       = 3;

   logic                 i_clk;
   logic                 i_rst;
   logic                 i_start;
   logic                 i_data_valid;
   logic [DATA_W-1:0]    i_data;
   logic                 o_busy;
   logic                 o_checking_done;
   logic                 o_valid_frame;
   logic                 o_timeout;
   logic [ERR_CNT_W-1:0] o_err_cnt;
   logic                 o_first_err_vld;
   logic [IDX_W-1:0]     o_first_err_idx;

   int errors = 0;
   int checks = 0;

   frame_checker #(
      .DATA_W      (DATA_W),
      .FRAME_LEN   (FRAME_LEN),
      .ERR_CNT_W   (ERR_CNT_W),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .SEED        (16'h0010)
   ) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_start         (i_start),
      .i_data_valid    (i_data_valid),
      .i_data          (i_data),
      .o_busy          (o_busy),
      .o_checking_done (o_checking_done),
      .o_valid_frame   (o_valid_frame),
      .o_timeout       (o_timeout),
      .o_err_cnt       (o_err_cnt),
      .o_first_err_vld (o_first_err_vld),
      .o_first_err_idx (o_first_err_idx)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [DATA_W-1:0] d);
      i_data_valid = 1'b1;
      i_data       = d;
      tick();
      i_data_valid = 1'b0;
      i_data       = '0;
   endtask

   task automatic start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   initial begin
      i_rst = 1'b1; i_start = 1'b0; i_data_valid = 1'b0; i_data = '0;
      tick(); tick();
      i_rst = 1'b0;
      tick();
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_checking_done, 0);
      chk("rst_valid", o_valid_frame, 0);
      chk("rst_timeout", o_timeout, 0);
      chk("rst_err_cnt", o_err_cnt, 0);
      chk("rst_first_vld", o_first_err_vld, 0);
      chk("rst_first_idx", o_first_err_idx, 0);

      // Clean contiguous frame
      start();
      chk("clean_busy", o_busy, 1);
      for (int k = 0; k < 8; k++) begin
         beat(16'h0010 + 16'(k));
         if (k == 6) chk("clean_no_early_done", o_checking_done, 0);
      end
      chk("clean_done", o_checking_done, 1);
      chk("clean_valid", o_valid_frame, 1);
      chk("clean_timeout", o_timeout, 0);
      chk("clean_err_cnt", o_err_cnt, 0);
      chk("clean_first_vld", o_first_err_vld, 0);
      tick();
      chk("clean_done_one_cycle", o_checking_done, 0);
      chk("clean_idle_busy", o_busy, 0);

      // Gapped frame: valid 1-0-0-1
      start();
      for (int k = 0; k < 8; k++) begin
         beat(16'h0010 + 16'(k));
         if (k < 7) begin
            tick(); tick();
            if (k == 6) chk("gap_no_early_done", o_checking_done, 0);
         end
      end
      chk("gap_done", o_checking_done, 1);
      chk("gap_valid", o_valid_frame, 1);
      chk("gap_err_cnt", o_err_cnt, 0);
      tick();

      // Corrupted beats 2 and 5
      start();
      for (int k = 0; k < 8; k++) begin
         beat((k == 2 || k == 5) ? 16'h00ff : 16'h0010 + 16'(k));
         if (k == 2) begin
            chk("corr_err_after_b2", o_err_cnt, 1);
            chk("corr_first_vld_b2", o_first_err_vld, 1);
            chk("corr_first_idx_b2", o_first_err_idx, 2);
         end
      end
      chk("corr_done", o_checking_done, 1);
      chk("corr_valid", o_valid_frame, 0);
      chk("corr_err_cnt", o_err_cnt, 2);
      chk("corr_first_idx", o_first_err_idx, 2);
      tick();
      chk("corr_hold_err", o_err_cnt, 2);
      chk("corr_hold_idx", o_first_err_idx, 2);

      // Overrun beats in IDLE poison the count and saturate
      beat(16'h0010);
      chk("overrun_err_cnt", o_err_cnt, 3);
      chk("overrun_no_done", o_checking_done, 0);
      beat(16'h0011);
      chk("overrun_sat", o_err_cnt, 3);

      // Saturation: 8 wrong beats on a 2-bit counter
      start();
      chk("sat_cleared", o_err_cnt, 0);
      chk("sat_first_cleared", o_first_err_vld, 0);
      for (int k = 0; k < 8; k++) beat(16'hbeef);
      chk("sat_done", o_checking_done, 1);
      chk("sat_err_cnt", o_err_cnt, 3);
      chk("sat_first_idx", o_first_err_idx, 0);
      chk("sat_valid", o_valid_frame, 0);
      tick();

      // Timeout: 3 beats then stall
      start();
      for (int k = 0; k < 3; k++) beat(16'h0010 + 16'(k));
      for (int i = 0; i < 15; i++) tick();
      chk("tmo_not_yet", o_checking_done, 0);
      chk("tmo_busy", o_busy, 1);
      tick();
      chk("tmo_done", o_checking_done, 1);
      chk("tmo_flag", o_timeout, 1);
      chk("tmo_valid", o_valid_frame, 0);
      chk("tmo_err_cnt", o_err_cnt, 0);
      tick();
      chk("tmo_pulse_end", o_timeout, 0);

      // Restart mid-frame with a simultaneous beat
      start();
      beat(16'h0010);
      beat(16'h0099);
      chk("rs_err_before", o_err_cnt, 1);
      i_start = 1'b1; i_data_valid = 1'b1; i_data = 16'h0010;
      tick();
      i_start = 1'b0; i_data_valid = 1'b0; i_data = '0;
      chk("rs_err_cleared", o_err_cnt, 0);
      chk("rs_first_cleared", o_first_err_vld, 0);
      chk("rs_busy", o_busy, 1);
      for (int k = 0; k < 8; k++) beat(16'h0010 + 16'(k));
      chk("rs_done", o_checking_done, 1);
      chk("rs_valid", o_valid_frame, 1);
      chk("rs_err_cnt", o_err_cnt, 0);
      tick();

      // Reset mid-frame
      start();
      beat(16'h0010);
      beat(16'h0077);
      beat(16'h0012);
      i_rst = 1'b1;
      tick();
      chk("mrst_done", o_checking_done, 0);
      chk("mrst_busy", o_busy, 0);
      chk("mrst_err_cnt", o_err_cnt, 0);
      chk("mrst_first_vld", o_first_err_vld, 0);
      i_rst = 1'b0;
      tick();
      chk("mrst_no_done_after", o_checking_done, 0);
      chk("mrst_idle", o_busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/frame_checker.md
Name: frame_checker

Overview:
- Parametrised successor to the single-frame RAM read-back checker; sits after the RAM read path in ram_system_design.
- Compares each received valid beat against an internally generated reference pattern and reports a pass/fail verdict per frame.
- Generalises width and frame length, tolerates gaps in i_data_valid, and counts errors with saturation.
- Captures the index of the first mismatch, detects overrun (excess beats), and times out on a stalled frame.

Parameters:
- DATA_W, 32, width of checked data word
- FRAME_LEN, 64, beats per frame (>=1)
- ERR_CNT_W, 8, width of saturating error counter
- TIMEOUT_CYC, 256, max idle cycles between beats before abort (>=2)
- SEED, 0, reference word for beat 0; beat k expects (SEED + k) mod 2^DATA_W

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_start  in  1  pulse; arms checker for a new frame
- i_data_valid  in  1  received beat qualifier
- i_data  in  DATA_W  received word
- o_busy  out  1  high in ARMED or CHECK
- o_checking_done  out  1  one-cycle pulse: frame verdict available
- o_valid_frame  out  1  one-cycle pulse with o_checking_done when frame passed
- o_timeout  out  1  one-cycle pulse with o_checking_done when aborted by timeout
- o_err_cnt  out  ERR_CNT_W  mismatches in current/last frame, saturating at all-ones
- o_first_err_vld  out  1  a mismatch was captured in current/last frame
- o_first_err_idx  out  clog2(FRAME_LEN) (min 1)  beat index of first mismatch

Behaviour:
- Interface: one clock, i_clk; reset i_rst is synchronous and active-high.
- Reset: FSM=IDLE; all outputs 0; beat counter, idle counter and ref word cleared (ref word = SEED).
- FSM states: IDLE, ARMED, CHECK, DONE.
  - IDLE: i_start -> ARMED.
  - ARMED: first valid beat -> CHECK.
  - CHECK: continues until beat FRAME_LEN-1 is consumed -> DONE.
  - DONE: one cycle only, then IDLE.
- i_start in any state: clear counters, error capture and ref word (=SEED); go to ARMED. A beat in the same cycle is ignored; start wins.
- Beat handling (ARMED/CHECK, i_data_valid=1):
  - compare i_data with ref word (SEED + beat_idx);
  - on mismatch, increment o_err_cnt unless saturated;
  - on the first mismatch, latch beat_idx into o_first_err_idx and set o_first_err_vld;
  - then advance beat_idx and ref word (wraps mod 2^DATA_W).
- Gaps: i_data_valid low cycles do not advance the reference; beats are matched by count, not cycle.
- Registered outputs: o_err_cnt and o_first_err_* update the cycle after the beat.
- Verdict latency: o_checking_done pulses exactly 1 clk after the last beat is sampled (in DONE).
  - o_valid_frame = 1 iff err count == 0 and no timeout.
- Single-beat frame (FRAME_LEN=1): the verdict follows the rules above with no special case.
- Timeout:
  - idle counter counts cycles without valid in ARMED/CHECK and resets on each beat;
  - at TIMEOUT_CYC go to DONE with o_timeout=1 and o_valid_frame=0;
  - error status is preserved.
- Overrun:
  - valid beats in IDLE/DONE with no i_start are not compared;
  - if o_err_cnt is not saturated, each such beat increments it (status only, no new done pulse).
  - Extra beats thus poison the next read of o_err_cnt until the next i_start.
- Error status is held after DONE until the next i_start or reset.
- o_busy is combinational from state.
- Reset mid-frame: abort immediately with no done pulse.

Decomposition:
- Shared package frame_check_pkg: FSM state encoding (IDLE=0, ARMED=1, CHECK=2, DONE=3), clog2 helper.
- Sub-module ref_pattern_gen: holds ref word.
  - Inputs: load (to SEED), advance.
  - Output: current expected word.
  - Keep it separate so other pattern types can replace it later without touching the FSM.

Test Plan:
- Clean frame: FRAME_LEN=8, SEED=0x10, start then 8 contiguous beats 0x10..0x17 -> done+valid 1 clk after last beat, err_cnt=0, first_err_vld=0.
- Gapped frame: same data, i_data_valid toggling 1-0-0-1 -> valid frame, done 1 clk after 8th beat.
- Corruption: beats 2 and 5 wrong -> err_cnt=2, first_err_idx=2, valid_frame=0, done=1.
- Saturation: ERR_CNT_W=2, 8 wrong beats -> err_cnt=3, no wrap.
- Timeout: TIMEOUT_CYC=16, send 3 beats then stop -> done+timeout 16 cycles after last beat, valid_frame=0.
- Restart/reset: i_start mid-frame with simultaneous beat -> beat ignored, counters 0, next 8 correct beats pass; i_rst mid-frame -> outputs 0, no done pulse.
